issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Per-warp register hazard tracker directly upstream of the operand-collector stage.
- Accepts decoded instructions in order and holds any instruction whose source or destination register is still pending writeback.
- Forwards hazard-free instructions through one registered output stage to the operand stage.
- Clears pending state from writeback-commit notifications.

Parameters:
NUM_WARPS, 4, warps tracked; WID_W = max(1, clog2(NUM_WARPS))
NUM_REGS, 32, architectural registers per warp; RID_W = clog2(NUM_REGS)
DATAW, 64, opaque instruction payload width (uuid, tmask, PC, op, args), passed through untouched

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  instruction accepted this cycle when high with in_valid
in_wid  in  WID_W  warp id
in_wb  in  1  instruction writes rd
in_rd  in  RID_W  destination register
in_rs1  in  RID_W  source 1
in_rs2  in  RID_W  source 2
in_rs3  in  RID_W  source 3
in_used_rs  in  3  per-source valid bits (bit0 = rs1)
in_data  in  DATAW  payload
out_valid  out  1  instruction valid to operand stage
out_ready  in  1  operand stage accepts
out_wid  out  WID_W  registered in_wid
out_wb  out  1  registered in_wb
out_rd  out  RID_W  registered in_rd
out_data  out  DATAW  registered payload
wb_valid  in  1  writeback commit
wb_wid  in  WID_W  writeback warp
wb_rd  in  RID_W  writeback register
wb_eop  in  1  last packet of writeback; only wb_valid && wb_eop releases rd
pending_any  out  NUM_WARPS  per-warp OR of pending bits (for warp scheduler)

Behaviour:
- State:
  - pending[NUM_WARPS][NUM_REGS], flops.
  - Output register: out_valid plus out_* fields.
- Reset: asynchronous, active-high. pending = 0, out_valid = 0, all out_* = 0, pending_any = 0. Reset mid-transfer drops the held instruction; no replay.
- Release: rel = wb_valid && wb_eop. It clears pending[wb_wid][wb_rd] at the clock edge.
- Effective pending view, used by the hazard check in the same cycle: eff = pending with bit [wb_wid][wb_rd] forced to 0 when rel. The release is bypassed, so an instruction whose only hazard is being released issues that cycle.
- hazard = OR of:
  - (in_used_rs[i] && eff[in_wid][rs_i]) for i = 0..2
  - (in_wb && eff[in_wid][in_rd]) — WAW check
- Register 0:
  - never set pending;
  - sources/dest equal to 0 never hazard;
  - writeback to r0 ignored.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready). in_ready depends combinationally on in_* and wb_*.
  - in_valid is not required to hold stable while in_ready is low; the hazard is re-evaluated every cycle.
- On in_fire (in_valid && in_ready):
  - Load out_* registers and set out_valid = 1.
  - If in_wb && in_rd != 0, set pending[in_wid][in_rd].
- Output: if out_valid && out_ready && !in_fire, clear out_valid. Full throughput: one instruction per cycle with no hazards and out_ready held high.
- Latency: in_fire to out_valid is 1 cycle.
- Simultaneous set and release of the same [wid][rd] bit: set wins, so the bit ends at 1.
- Simultaneous set and release of different bits: both apply.
- pending_any[w] is the OR of the registered pending[w] after the edge, not the bypassed view.
- Writeback for a register not pending: no effect. No error is flagged.

Optional Feature:
SCOREBOARD_TIMEOUT_EN
- With the macro defined, adds:
  - parameter STALL_TIMEOUT, default 4096;
  - output port timeout (1 bit);
  - output port timeout_wid (WID_W).
- A 13-bit saturating counter increments each cycle in_valid && hazard holds. It resets to 0 on in_fire, on !in_valid, or on reset.
- When the counter reaches STALL_TIMEOUT:
  - timeout sets and stays set (sticky) until reset;
  - timeout_wid latches in_wid.
- Without the macro: no counter, and no timeout or timeout_wid ports.

Test Plan:
- Reset then idle: out_valid = 0, pending_any = 4'b0000. Assert reset asynchronously mid-cycle with out_valid = 1 -> out_valid drops immediately, before the next edge.
- RAW stall: issue w0 wb rd=5, then w0 rs1=5 -> first fires at cycle 0, second held (in_ready = 0). pending_any[0] = 1 from cycle 1. Pulse wb w0 rd=5 eop=1 at cycle 3 -> second fires at cycle 3 (bypass), out_valid at cycle 4.
- Multi-packet writeback: wb w0 rd=5 with eop=0 -> still stalled. Same with eop=1 -> released.
- Set/release collision: at the same edge, release w1 rd=7 and fire w1 wb rd=7, with rd=7 hazard-free via bypass -> pending[1][7] = 1 afterwards, pending_any[1] = 1.
- Backpressure and throughput:
  - 8 independent instructions on w0..w3 (rd distinct, r0 sources), out_ready = 1 -> 8 consecutive out_valid cycles, order preserved.
  - Drop out_ready for 3 cycles -> out_* stable and in_ready = 0 during the drop.
  - r0 writes leave pending_any unchanged.
- With SCOREBOARD_TIMEOUT_EN and STALL_TIMEOUT = 16: hold w2 rs1=9 pending with no writeback -> timeout = 1 after 16 stall cycles, timeout_wid = 2. timeout stays 1 after the stall clears, until reset.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Per-warp register hazard scoreboard feeding the operand collector through one output register.
// Optional stall watchdog enabled by defining SCOREBOARD_TIMEOUT_EN (adds timeout/timeout_wid ports).
module issue_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 32,
    parameter int DATAW     = 64,
`ifdef SCOREBOARD_TIMEOUT_EN
    parameter int STALL_TIMEOUT = 4096,
`endif
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RID_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WID_W-1:0]     in_wid,
    input  logic                 in_wb,
    input  logic [RID_W-1:0]     in_rd,
    input  logic [RID_W-1:0]     in_rs1,
    input  logic [RID_W-1:0]     in_rs2,
    input  logic [RID_W-1:0]     in_rs3,
    input  logic [2:0]           in_used_rs,
    input  logic [DATAW-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WID_W-1:0]     out_wid,
    output logic                 out_wb,
    output logic [RID_W-1:0]     out_rd,
    output logic [DATAW-1:0]     out_data,
    input  logic                 wb_valid,
    input  logic [WID_W-1:0]     wb_wid,
    input  logic [RID_W-1:0]     wb_rd,
    input  logic                 wb_eop,
    output logic [NUM_WARPS-1:0] pending_any
`ifdef SCOREBOARD_TIMEOUT_EN
    ,
    output logic                 timeout,
    output logic [WID_W-1:0]     timeout_wid
`endif
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_q, pending_d, eff;
    logic                 rel;
    logic                 hazard;
    logic                 in_fire;
    logic                 out_valid_q;
    logic [WID_W-1:0]     out_wid_q;
    logic                 out_wb_q;
    logic [RID_W-1:0]     out_rd_q;
    logic [DATAW-1:0]     out_data_q;

    // Only the last writeback packet retires the destination register.
    assign rel = wb_valid && wb_eop;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eff = pending_q;
        if (rel) begin
            eff[wb_wid][wb_rd] = 1'b0;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (in_used_rs[0] && (in_rs1 != '0) && eff[in_wid][in_rs1]) hazard = 1'b1;
        if (in_used_rs[1] && (in_rs2 != '0) && eff[in_wid][in_rs2]) hazard = 1'b1;
        if (in_used_rs[2] && (in_rs3 != '0) && eff[in_wid][in_rs3]) hazard = 1'b1;
        if (in_wb && (in_rd != '0) && eff[in_wid][in_rd])           hazard = 1'b1;
    end

    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        pending_d = pending_q;
        if (rel && (wb_rd != '0)) begin
            pending_d[wb_wid][wb_rd] = 1'b0;
        end
        // Applied after the release so a same-bit collision leaves the register pending.
        if (in_fire && in_wb && (in_rd != '0)) begin
            pending_d[in_wid][in_rd] = 1'b1;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the pending array is plain flops, not RAM, so it is cleared by reset along with the output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_wb_q    <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (in_fire) begin
                out_valid_q <= 1'b1;
                out_wid_q   <= in_wid;
                out_wb_q    <= in_wb;
                out_rd_q    <= in_rd;
                out_data_q  <= in_data;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_wid   = out_wid_q;
    assign out_wb    = out_wb_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;

    // Scheduler hint reflects committed state only, never the same-cycle bypass.
    always_comb begin
        pending_any = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_any[w] = |pending_q[w];
        end
    end

`ifdef SCOREBOARD_TIMEOUT_EN
    localparam int CNT_W = 13;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q;
    logic [WID_W-1:0] timeout_wid_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!in_valid || in_fire) begin
            stall_cnt_d = '0;
        end else if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Sticky: the first warp to hit the limit is the one reported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            timeout_wid_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (!timeout_q && (stall_cnt_d == CNT_W'(STALL_TIMEOUT))) begin
                timeout_q     <= 1'b1;
                timeout_wid_q <= in_wid;
            end
        end
    end

    assign timeout     = timeout_q;
    assign timeout_wid = timeout_wid_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, corner sequences and a randomized run against a reference model.
// Define SCOREBOARD_TIMEOUT_EN for both files to also exercise the stall watchdog.
module tb_issue_scoreboard;

    localparam int NW = 4;
    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_wid = '0;
    logic        in_wb = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
    logic [2:0]  in_used_rs = '0;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_wid;
    logic        out_wb;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_wid = '0;
    logic [4:0]  wb_rd = '0;
    logic        wb_eop = 1'b0;
    logic [3:0]  pending_any;
`ifdef SCOREBOARD_TIMEOUT_EN
    logic        timeout;
    logic [1:0]  timeout_wid;
`endif

    always #5 clk = ~clk;

`ifdef SCOREBOARD_TIMEOUT_EN
    issue_scoreboard #(.NUM_WARPS(NW), .NUM_REGS(NR), .DATAW(64), .STALL_TIMEOUT(16)) dut (
`else
    issue_scoreboard #(.NUM_WARPS(NW), .NUM_REGS(NR), .DATAW(64)) dut (
`endif
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_used_rs(in_used_rs), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_wb(out_wb),
        .out_rd(out_rd), .out_data(out_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .pending_any(pending_any)
`ifdef SCOREBOARD_TIMEOUT_EN
        , .timeout(timeout), .timeout_wid(timeout_wid)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of pending (warp, reg) pairs plus the expected output-stage contents.
    bit          pend[NW][NR];
    bit          m_ov;
    logic [1:0]  m_wid;
    bit          m_wb;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    bit          m_ready;

    function automatic bit busy(input int w, input int r);
        bool_released: begin end
        if (r == 0) return 1'b0;
        if (wb_valid && wb_eop && (int'(wb_wid) == w) && (int'(wb_rd) == r)) return 1'b0;
        return pend[w][r];
    endfunction

    function automatic logic [3:0] model_pany();
        logic [3:0] p = '0;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                if (pend[w][r]) p[w] = 1'b1;
        return p;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                pend[w][r] = 1'b0;
        m_ov = 1'b0;
    endtask

    // Compare DUT against model at the falling edge, with inputs stable.
    task automatic model_eval();
        bit haz = 1'b0;
        if (in_used_rs[0] && busy(in_wid, in_rs1)) haz = 1'b1;
        if (in_used_rs[1] && busy(in_wid, in_rs2)) haz = 1'b1;
        if (in_used_rs[2] && busy(in_wid, in_rs3)) haz = 1'b1;
        if (in_wb && busy(in_wid, in_rd)) haz = 1'b1;
        m_ready = !haz && (!m_ov || out_ready);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_wid", out_wid, m_wid);
            check("out_wb", out_wb, m_wb);
            check("out_rd", out_rd, m_rd);
            check("out_data", out_data, m_data);
        end
        check("pending_any", pending_any, model_pany());
    endtask

    task automatic model_update();
        bit fire = in_valid && m_ready;
        if (wb_valid && wb_eop) pend[wb_wid][wb_rd] = 1'b0;
        if (fire && in_wb && (in_rd != 0)) pend[in_wid][in_rd] = 1'b1;
        if (fire) begin
            m_ov = 1'b1; m_wid = in_wid; m_wb = in_wb; m_rd = in_rd; m_data = in_data;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_wb = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        in_used_rs = '0; in_wid = '0; wb_valid = 1'b0; wb_eop = 1'b0; wb_rd = '0; wb_wid = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b1;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        bit         iv;
        logic [1:0] wid;
        bit         wb;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [2:0] used;
        bit         wbv;
        logic [4:0] wbrd;
        bit         eop;
        bit         exp_ready;
        bit         exp_ov;
        logic [3:0] exp_pany;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // iv wid wb rd rs1 used wbv wbrd eop | ready ov pany
        vecs[0]  = '{1, 0, 1, 5, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};
        vecs[1]  = '{1, 0, 0, 0, 5, 3'b001, 0, 0, 0, 0, 1, 4'b0001};
        vecs[2]  = '{1, 0, 0, 0, 5, 3'b001, 0, 0, 0, 0, 0, 4'b0001};
        vecs[3]  = '{1, 0, 0, 0, 5, 3'b001, 1, 5, 0, 0, 0, 4'b0001};
        vecs[4]  = '{1, 0, 0, 0, 5, 3'b001, 1, 5, 1, 1, 0, 4'b0001};
        vecs[5]  = '{0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 4'b0000};
        vecs[6]  = '{1, 1, 1, 7, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};
        vecs[7]  = '{0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 4'b0010};
        vecs[8]  = '{1, 1, 1, 7, 0, 3'b000, 1, 7, 1, 1, 0, 4'b0010};
        vecs[9]  = '{0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 4'b0010};
        vecs[10] = '{0, 1, 0, 0, 0, 3'b000, 1, 7, 1, 1, 0, 4'b0010};
        vecs[11] = '{0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};
        vecs[12] = '{1, 2, 1, 0, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};
        vecs[13] = '{0, 2, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 4'b0000};
        vecs[14] = '{1, 3, 1, 9, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};
        vecs[15] = '{1, 3, 1, 9, 0, 3'b000, 0, 0, 0, 0, 1, 4'b1000};
        vecs[16] = '{1, 3, 1, 9, 0, 3'b000, 1, 9, 1, 1, 0, 4'b1000};
        vecs[17] = '{0, 3, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 4'b1000};
        vecs[18] = '{0, 3, 0, 0, 0, 3'b000, 1, 9, 1, 1, 0, 4'b1000};
        vecs[19] = '{0, 3, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 4'b0000};

        // Reset state
        do_reset();
        check("reset out_valid", out_valid, 1'b0);
        check("reset pending_any", pending_any, 4'b0000);
        check("reset out_data", out_data, 64'h0);
        check("reset out_rd", out_rd, 5'h0);

        // Directed table: RAW stall, multi-packet writeback, set/release collision, r0, WAW
        for (int i = 0; i < 20; i++) begin
            in_valid = vecs[i].iv; in_wid = vecs[i].wid; in_wb = vecs[i].wb; in_rd = vecs[i].rd;
            in_rs1 = vecs[i].rs1; in_rs2 = '0; in_rs3 = '0; in_used_rs = vecs[i].used;
            in_data = 64'(i) | 64'hA5A5_0000_0000_0000;
            wb_valid = vecs[i].wbv; wb_wid = vecs[i].wid; wb_rd = vecs[i].wbrd; wb_eop = vecs[i].eop;
            @(negedge clk);
            model_eval();
            check($sformatf("vec%0d ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_ov);
            check($sformatf("vec%0d pending_any", i), pending_any, vecs[i].exp_pany);
            @(posedge clk);
            model_update();
            #1;
        end
        idle_inputs();
        cycle();

        // Throughput: 8 independent instructions back to back
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_wid = 2'(i % 4); in_wb = 1'b1; in_rd = 5'(10 + i);
            in_used_rs = 3'b111; in_data = 64'h1000 + 64'(i);
            cycle();
            check("throughput fire", m_ready, 1'b1);
        end
        // Backpressure: hold the last output for 3 cycles with a new instruction waiting
        in_wid = 2'd0; in_rd = 5'd20; in_data = 64'hBEEF;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall out_data", out_data, 64'h1007);
            check("stall in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Asynchronous reset mid-cycle drops a held instruction immediately
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_wb = 1'b1; in_rd = 5'd3; in_data = 64'h55;
        cycle();
        idle_inputs();
        check("pre-reset out_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset pending_any", pending_any, 4'b0000);
        do_reset();

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_wid = 2'($urandom);
            in_wb = 1'($urandom);
            in_rd = 5'($urandom_range(0, 7));
            in_rs1 = 5'($urandom_range(0, 7));
            in_rs2 = 5'($urandom_range(0, 7));
            in_rs3 = 5'($urandom_range(0, 7));
            in_used_rs = 3'($urandom);
            in_data = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 3) != 0);
            wb_valid = 1'($urandom);
            wb_wid = 2'($urandom);
            wb_rd = 5'($urandom_range(0, 7));
            wb_eop = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

`ifdef SCOREBOARD_TIMEOUT_EN
        // Stall watchdog with limit 16
        do_reset();
        in_valid = 1'b1; in_wid = 2'd2; in_wb = 1'b1; in_rd = 5'd9;
        cycle();
        in_wb = 1'b0; in_rd = '0; in_rs1 = 5'd9; in_used_rs = 3'b001;
        repeat (15) cycle();
        check("timeout before limit", timeout, 1'b0);
        cycle();
        check("timeout at limit", timeout, 1'b1);
        check("timeout_wid", timeout_wid, 2'd2);
        wb_valid = 1'b1; wb_wid = 2'd2; wb_rd = 5'd9; wb_eop = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("timeout sticky", timeout, 1'b1);
        do_reset();
        check("timeout cleared", timeout, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
